// File: rtl/lvds_sync_pkg.sv
// Shared types and defaults for the LVDS word-alignment controller.
package lvds_sync_pkg;

    localparam int unsigned DEF_WORD_W = 16;
    localparam logic [DEF_WORD_W-1:0] DEF_SYNC_WORD = 16'h5511;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } sync_state_e;

    // Bits needed to hold a count running from 0 up to n inclusive.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/lvds_sipo_shreg.sv
// Serial-in/parallel-out shift register, MSB first, with a sync-word match flag.
module lvds_sipo_shreg
    import lvds_sync_pkg::*;
#(
    parameter int unsigned       WORD_W    = DEF_WORD_W,
    parameter logic [WORD_W-1:0] SYNC_WORD = DEF_SYNC_WORD
) (
    input  logic              lvds_clk,
    input  logic              rst,
    input  logic              lvds_in,
    output logic [WORD_W-1:0] shreg,
    output logic              match
);

    logic [WORD_W-1:0] shreg_d, shreg_q;

    // Keeps shifting regardless of enable so alignment can be reacquired quickly.
    always_comb begin
        shreg_d = {shreg_q[WORD_W-2:0], lvds_in};
    end

    always_ff @(posedge lvds_clk) begin
        if (rst) shreg_q <= '0;
        else     shreg_q <= shreg_d;
    end

    assign shreg = shreg_q;
    assign match = (shreg_q == SYNC_WORD);

endmodule

// File: rtl/lvds_frame_sync_ctrl.sv
// Word-alignment controller: hunt for the sync word, verify over several frames,
// then emit aligned words until repeated sync misses drop lock.
//   state  | meaning
//   HUNT   | bit-by-bit search for the sync word
//   VERIFY | aligned, counting consecutive sync-slot hits toward lock
//   LOCKED | emitting aligned words, counting sync-slot misses
module lvds_frame_sync_ctrl
    import lvds_sync_pkg::*;
#(
    parameter int unsigned       WORD_W     = DEF_WORD_W,
    parameter logic [WORD_W-1:0] SYNC_WORD  = DEF_SYNC_WORD,
    parameter int unsigned       FRAME_LEN  = 1,
    parameter int unsigned       LOCK_CNT   = 3,
    parameter int unsigned       UNLOCK_CNT = 2
) (
    input  logic              lvds_clk,
    input  logic              rst,
    input  logic              en,
    input  logic              lvds_in,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    output logic              word_sof,
    output logic              locked,
    output logic              sync_err
);

    localparam int unsigned BIT_W  = $clog2(WORD_W);
    localparam int unsigned IDX_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned GOOD_W = cnt_w(LOCK_CNT);
    localparam int unsigned MISS_W = cnt_w(UNLOCK_CNT);

    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(WORD_W - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE    = (FRAME_LEN > 1) ? IDX_W'(1) : '0;
    localparam logic [GOOD_W-1:0] LOCK_VAL   = GOOD_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0] UNLOCK_VAL = MISS_W'(UNLOCK_CNT);

    logic [WORD_W-1:0] shreg;
    logic              match;

    lvds_sipo_shreg #(
        .WORD_W    (WORD_W),
        .SYNC_WORD (SYNC_WORD)
    ) u_shreg (
        .lvds_clk (lvds_clk),
        .rst      (rst),
        .lvds_in  (lvds_in),
        .shreg    (shreg),
        .match    (match)
    );

    sync_state_e       state_d, state_q;
    logic [BIT_W-1:0]  bit_cnt_d, bit_cnt_q;
    logic [IDX_W-1:0]  word_idx_d, word_idx_q;
    logic [GOOD_W-1:0] good_cnt_d, good_cnt_q, good_inc;
    logic [MISS_W-1:0] miss_cnt_d, miss_cnt_q, miss_inc;
    logic [WORD_W-1:0] word_out_d, word_out_q;
    logic              word_valid_d, word_valid_q;
    logic              word_sof_d, word_sof_q;
    logic              locked_d, locked_q;
    logic              sync_err_d, sync_err_q;
    logic              bnd, sync_slot;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        word_idx_d   = word_idx_q;
        good_cnt_d   = good_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        word_out_d   = word_out_q;
        word_valid_d = 1'b0;
        word_sof_d   = 1'b0;
        sync_err_d   = 1'b0;
        good_inc     = good_cnt_q + GOOD_W'(1);
        miss_inc     = miss_cnt_q + MISS_W'(1);
        bnd          = (state_q != HUNT) && (bit_cnt_q == '0);
        sync_slot    = bnd && (word_idx_q == '0);

        if (state_q != HUNT) begin
            bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BIT_W'(1);
            if (bnd) word_idx_d = (word_idx_q == IDX_LAST) ? '0 : word_idx_q + IDX_W'(1);
        end

        case (state_q)
            HUNT: begin
                if (match) begin
                    bit_cnt_d  = BIT_W'(1);
                    word_idx_d = IDX_ONE;
                    good_cnt_d = GOOD_W'(1);
                    miss_cnt_d = '0;
                    state_d    = (LOCK_CNT == 1) ? LOCKED : VERIFY;
                end
            end
            VERIFY: begin
                if (sync_slot) begin
                    if (match) begin
                        good_cnt_d = good_inc;
                        if (good_inc == LOCK_VAL) begin
                            state_d    = LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        state_d = HUNT;
                    end
                end
            end
            LOCKED: begin
                if (bnd) begin
                    word_out_d   = shreg;
                    word_valid_d = 1'b1;
                    word_sof_d   = (word_idx_q == '0);
                end
                if (sync_slot) begin
                    if (match) begin
                        miss_cnt_d = '0;
                    end else begin
                        sync_err_d = 1'b1;
                        miss_cnt_d = miss_inc;
                        if (miss_inc == UNLOCK_VAL) state_d = HUNT;
                    end
                end
            end
            default: state_d = HUNT;
        endcase

        // Every entry into HUNT starts the search from a clean slate.
        if (state_d == HUNT) begin
            bit_cnt_d  = '0;
            word_idx_d = '0;
            good_cnt_d = '0;
            miss_cnt_d = '0;
        end

        if (!en) begin
            state_d      = HUNT;
            bit_cnt_d    = '0;
            word_idx_d   = '0;
            good_cnt_d   = '0;
            miss_cnt_d   = '0;
            word_out_d   = '0;
            word_valid_d = 1'b0;
            word_sof_d   = 1'b0;
            sync_err_d   = 1'b0;
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge lvds_clk) begin
        if (rst) begin
            state_q      <= HUNT;
            bit_cnt_q    <= '0;
            word_idx_q   <= '0;
            good_cnt_q   <= '0;
            miss_cnt_q   <= '0;
            word_out_q   <= '0;
            word_valid_q <= 1'b0;
            word_sof_q   <= 1'b0;
            locked_q     <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            word_idx_q   <= word_idx_d;
            good_cnt_q   <= good_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            word_out_q   <= word_out_d;
            word_valid_q <= word_valid_d;
            word_sof_q   <= word_sof_d;
            locked_q     <= locked_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;
    assign word_sof   = word_sof_q;
    assign locked     = locked_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_lvds_frame_sync_ctrl.sv
// Scoreboard bench: two controllers (FRAME_LEN 1 and 4) share one serial stream;
// a timestamp-based frame model predicts each output word and the lock flag.
module tb_lvds_frame_sync_ctrl;

    localparam int          W       = 16;
    localparam logic [15:0] SYNC    = 16'h5511;
    localparam int          LOCKN   = 3;
    localparam int          UNLOCKN = 2;
    localparam int          MH = 0, MV = 1, ML = 2;

    logic lvds_clk = 1'b0;
    logic rst      = 1'b1;
    logic en       = 1'b1;
    logic lvds_in  = 1'b0;

    logic [15:0] wo_a, wo_b;
    logic        wv_a, wv_b, ws_a, ws_b, lk_a, lk_b, se_a, se_b;

    always #5 lvds_clk = ~lvds_clk;

    lvds_frame_sync_ctrl #(.WORD_W(W), .SYNC_WORD(SYNC), .FRAME_LEN(1),
                           .LOCK_CNT(LOCKN), .UNLOCK_CNT(UNLOCKN)) dut_a (
        .lvds_clk(lvds_clk), .rst(rst), .en(en), .lvds_in(lvds_in),
        .word_out(wo_a), .word_valid(wv_a), .word_sof(ws_a),
        .locked(lk_a), .sync_err(se_a));

    lvds_frame_sync_ctrl #(.WORD_W(W), .SYNC_WORD(SYNC), .FRAME_LEN(4),
                           .LOCK_CNT(LOCKN), .UNLOCK_CNT(UNLOCKN)) dut_b (
        .lvds_clk(lvds_clk), .rst(rst), .en(en), .lvds_in(lvds_in),
        .word_out(wo_b), .word_valid(wv_b), .word_sof(ws_b),
        .locked(lk_b), .sync_err(se_b));

    typedef struct packed {
        int          cyc;
        logic [15:0] word;
        logic        sof;
        logic        err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int popped[2]   = '{0, 0};

    int          m_mode[2], m_next[2], m_slot[2], m_hits[2], m_miss[2];
    logic        m_locked[2], m_clr[2];
    logic [15:0] m_win = '0;

    // Reference: boundaries are absolute cycle numbers, slots are frame positions.
    task automatic model_step(input int k);
        int   fl;
        logic hit;
        exp_t e;
        fl       = (k == 0) ? 1 : 4;
        hit      = (m_win == SYNC);
        m_clr[k] = 1'b0;
        if (rst || !en) begin
            m_mode[k] = MH; m_hits[k] = 0; m_miss[k] = 0; m_clr[k] = 1'b1;
        end else begin
            case (m_mode[k])
                MH: if (hit) begin
                    m_hits[k] = 1; m_miss[k] = 0;
                    m_slot[k] = 1 % fl;
                    m_next[k] = cyc + W;
                    m_mode[k] = MV;
                end
                MV: if (cyc == m_next[k]) begin
                    if (m_slot[k] == 0) begin
                        if (hit) begin
                            m_hits[k] = m_hits[k] + 1;
                            if (m_hits[k] == LOCKN) begin m_mode[k] = ML; m_miss[k] = 0; end
                        end else begin
                            m_mode[k] = MH; m_hits[k] = 0;
                        end
                    end
                    m_slot[k] = (m_slot[k] + 1) % fl;
                    m_next[k] = m_next[k] + W;
                end
                default: if (cyc == m_next[k]) begin
                    e.cyc  = cyc + 1;
                    e.word = m_win;
                    e.sof  = (m_slot[k] == 0);
                    e.err  = (m_slot[k] == 0) && !hit;
                    if (k == 0) q0.push_back(e); else q1.push_back(e);
                    if (e.err) begin
                        m_miss[k] = m_miss[k] + 1;
                        if (m_miss[k] == UNLOCKN) m_mode[k] = MH;
                    end else if (m_slot[k] == 0) begin
                        m_miss[k] = 0;
                    end
                    m_slot[k] = (m_slot[k] + 1) % fl;
                    m_next[k] = m_next[k] + W;
                end
            endcase
        end
        m_locked[k] = (m_mode[k] == ML);
    endtask

    always @(posedge lvds_clk) begin
        for (int k = 0; k < 2; k++) model_step(k);
        if (rst) m_win = '0;
        else     m_win = {m_win[14:0], lvds_in};
        cyc = cyc + 1;
    end

    function automatic int q_size(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t q_pop(input int k);
        if (k == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic int q_front_cyc(input int k);
        return (k == 0) ? q0[0].cyc : q1[0].cyc;
    endfunction

    task automatic check_dut(input int k, input logic [15:0] wo, input logic wv,
                             input logic ws, input logic lk, input logic se);
        exp_t e;
        vectors++;
        if (lk !== m_locked[k]) begin
            miscompares++;
            $display("FAIL locked dut%0d cyc=%0d got=%b want=%b", k, cyc, lk, m_locked[k]);
        end
        if (m_clr[k]) begin
            vectors++;
            if ({wo, wv, ws, se} !== 19'd0) begin
                miscompares++;
                $display("FAIL clear dut%0d cyc=%0d got word=%h v=%b sof=%b err=%b want all 0",
                         k, cyc, wo, wv, ws, se);
            end
        end
        if (q_size(k) > 0 && q_front_cyc(k) < cyc) begin
            e = q_pop(k);
            vectors++; miscompares++;
            $display("FAIL missing_word dut%0d cyc=%0d got no strobe want word=%h at cyc=%0d",
                     k, cyc, e.word, e.cyc);
        end
        if (wv) begin
            vectors++;
            if (q_size(k) == 0) begin
                miscompares++;
                $display("FAIL spurious_valid dut%0d cyc=%0d got word=%h want no strobe", k, cyc, wo);
            end else begin
                e = q_pop(k);
                popped[k]++;
                if (e.cyc != cyc || wo !== e.word || ws !== e.sof || se !== e.err) begin
                    miscompares++;
                    $display("FAIL word dut%0d got cyc=%0d word=%h sof=%b err=%b want cyc=%0d word=%h sof=%b err=%b",
                             k, cyc, wo, ws, se, e.cyc, e.word, e.sof, e.err);
                end
            end
        end else if (ws || se) begin
            vectors++; miscompares++;
            $display("FAIL strobe_without_valid dut%0d cyc=%0d got sof=%b err=%b want 0", k, cyc, ws, se);
        end
    endtask

    always @(negedge lvds_clk) begin
        if (cyc > 0) begin
            check_dut(0, wo_a, wv_a, ws_a, lk_a, se_a);
            check_dut(1, wo_b, wv_b, ws_b, lk_b, se_b);
        end
    end

    task automatic send_bit(input logic b);
        lvds_in = b;
        @(posedge lvds_clk);
        #2;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
    endtask

    // Sync word with a one-cycle rst (use_rst=1) or en=0 pulse on bit 'pos'.
    task automatic send_word_pulse(input logic [15:0] w, input int pos, input logic use_rst);
        for (int i = 15; i >= 0; i--) begin
            if (i == pos) begin
                if (use_rst) rst = 1'b1; else en = 1'b0;
            end
            send_bit(w[i]);
            rst = 1'b0;
            en  = 1'b1;
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) send_bit(1'($urandom));
        rst = 1'b0;
    endtask

    function automatic logic [15:0] flip1(input logic [15:0] w);
        logic [15:0] m;
        m = 16'h0001 << $urandom_range(15);
        return w ^ m;
    endfunction

    initial begin
        logic [15:0] w;
        do_reset(3);
        repeat (8) send_word(SYNC);

        do_reset(2);
        repeat (5) send_bit(1'($urandom));
        repeat (8) send_word(SYNC);
        send_word(flip1(SYNC));
        send_word(flip1(SYNC));
        repeat (6) send_word(SYNC);

        do_reset(2);
        for (int f = 0; f < 8; f++) begin
            send_word(SYNC);
            w = (f == 5) ? flip1(16'h1234) : 16'h1234;
            send_word(w);
            send_word(16'hABCD);
            send_word(16'h0F0F);
        end

        do_reset(1);
        repeat (6) send_word(SYNC);
        send_word_pulse(SYNC, 7, 1'b1);
        repeat (6) send_word(SYNC);
        send_word_pulse(SYNC, 9, 1'b0);
        repeat (6) send_word(SYNC);

        do_reset(2);
        send_word(SYNC);
        send_word(SYNC);
        send_word(flip1(SYNC));
        repeat (5) send_word(SYNC);

        do_reset(1);
        for (int i = 0; i < 60; i++) begin
            w = ($urandom_range(3) == 0) ? 16'($urandom) : SYNC;
            send_word(w);
        end
        repeat (40) send_bit(1'b0);

        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (q_size(k) != 0) begin
                miscompares++;
                $display("FAIL leftover dut%0d got %0d pending want 0", k, q_size(k));
            end
            vectors++;
            if (popped[k] < 10) begin
                miscompares++;
                $display("FAIL word_count dut%0d got %0d want >= 10", k, popped[k]);
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/lvds_frame_sync_ctrl.md
Name: lvds_frame_sync_ctrl

Overview:
Word-alignment controller for the serial LVDS receive path. It shifts in the 1-bit lvds_in stream, hunts for a programmable sync word, and verifies it over several frames before declaring lock. While locked it emits aligned parallel words with a valid strobe and start-of-frame flag. It drops lock after repeated sync misses. It sits between the serial input pin logic and the parallel consumer, and replaces free-running deserialisation with sequenced, framed output.

Parameters:
WORD_W, 16, word width in bits; the serial stream is MSB first.
SYNC_WORD, 16'h5511, alignment pattern expected in word slot 0 of every frame.
FRAME_LEN, 1, words per frame including the sync word. Range 1..256.
LOCK_CNT, 3, number of consecutive sync hits (including the first) required to lock.
UNLOCK_CNT, 2, number of consecutive sync misses while locked that force a return to HUNT.

Ports:
lvds_clk  in  1  bit clock; all logic is on the rising edge.
rst  in  1  synchronous, active-high reset.
en  in  1  enable; low acts as a synchronous soft clear to HUNT.
lvds_in  in  1  serial data, sampled on each rising edge.
word_out  out  WORD_W  aligned word; valid only when word_valid is high.
word_valid  out  1  single-cycle strobe, asserted once per aligned word while LOCKED.
word_sof  out  1  high together with word_valid when the word is slot 0 (the sync word).
locked  out  1  registered; high while in LOCKED state.
sync_err  out  1  single-cycle pulse on each sync-slot miss while LOCKED.

Behaviour:
- Interface: one clock, lvds_clk. Reset rst is synchronous and active-high.
- Reset: shreg=0, state=HUNT, bit_cnt=0, word_idx=0, good_cnt=0, miss_cnt=0. All outputs are 0. Reset mid-operation behaves identically to power-up.
- en=0: same clear as reset, but shreg keeps shifting.
- Shifting: every cycle, shreg <= {shreg[WORD_W-2:0], lvds_in}.
- Boundary: "bnd" is true when state != HUNT and bit_cnt == 0. At bnd, shreg holds an aligned word. bit_cnt increments modulo WORD_W every cycle outside HUNT.
- word_idx increments modulo FRAME_LEN at each bnd. "sync slot" means bnd with word_idx == 0.
- HUNT:
  - Each cycle, compare shreg == SYNC_WORD.
  - On a hit: go to VERIFY, bit_cnt <= 1, word_idx <= 1 mod FRAME_LEN, good_cnt <= 1.
  - If LOCK_CNT == 1, go directly to LOCKED instead.
- VERIFY:
  - At a sync slot with a hit: good_cnt++. When the incremented value equals LOCK_CNT, go to LOCKED and set miss_cnt <= 0.
  - At a sync slot with a miss: go to HUNT, good_cnt <= 0.
  - Non-sync slots are ignored.
  - No words are output in VERIFY.
- LOCKED:
  - At every bnd: word_out <= shreg, word_valid <= 1, word_sof <= (word_idx == 0). All are registered, so they appear one cycle after bnd.
  - Sync-slot hit: miss_cnt <= 0.
  - Sync-slot miss: sync_err <= 1, miss_cnt++. When the incremented value equals UNLOCK_CNT, go to HUNT and set locked <= 0 on the same edge.
  - The word at the final miss is still output, with word_valid=1 and word_sof=1.
- Output hold: word_out holds its last value between strobes. word_valid, word_sof and sync_err are 0 in all other cycles.
- locked: registered, equal to (next_state == LOCKED), so it rises on the same edge the state enters LOCKED.
- Latency example (FRAME_LEN=1, LOCK_CNT=3):
  - First hit seen with shreg==SYNC at cycle t.
  - Subsequent hits at t+16 and t+32; locked=1 from t+33.
  - First word_valid at t+49.
- Simultaneous events: rst has priority over en, and en over state logic. A single miss in VERIFY always returns to HUNT; there is no tolerance before lock.
- Widths:
  - bit_cnt: $clog2(WORD_W) bits.
  - word_idx: max(1, $clog2(FRAME_LEN)) bits.
  - good_cnt / miss_cnt: sized for LOCK_CNT / UNLOCK_CNT, saturate-free (reset before overflow).

Decomposition:
- Package lvds_sync_pkg:
  - state enum {HUNT, VERIFY, LOCKED}.
  - Default SYNC_WORD and WORD_W constants.
- One sub-module, lvds_sipo_shreg: the WORD_W serial-in/parallel-out shift register with match output. The FSM and counters stay in the top.

Test Plan:
1. Continuous 0x5511 stream MSB first, 16-bit repeat, FRAME_LEN=1, starting after rst → locked rises 33 cycles after the first aligned hit. word_valid then pulses every 16 cycles with word_out=16'h5511 and word_sof=1.
2. Same stream preceded by 5 random bits (misaligned start) → lock still occurs, and every word_out equals 16'h5511.
3. Locked, then flip one bit in two consecutive sync words → sync_err pulses twice, 16 cycles apart, and locked falls after the second. A clean stream re-locks after 3 further sync words.
4. FRAME_LEN=4 with frames {5511, 1234, ABCD, 0F0F} → word_sof only on 5511, and word_out sequence 5511, 1234, ABCD, 0F0F repeats. Corrupting a data word does not raise sync_err.
5. rst asserted for 1 cycle while LOCKED mid-word → all outputs 0 the next cycle, and re-lock follows the case-1 timing. en=0 for 1 cycle gives the same result.
6. In VERIFY after 2 hits, corrupt the next sync word → return to HUNT, with no word_valid and no locked assertion.
